pipe_stage_skid_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage MIPS core; generalises the D->E latch.

---
 rtl/pipe_stage_skid_reg.sv | 183 ++++++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready inter-stage pipeline register with a
// two-entry (MAIN + SKID) buffer, registered in_ready_o and priority flush.
// Every Tnew field counts down once per clock edge while its entry sits in
// the stage, saturating at zero.
//
// Optional feature macro: PIPE_STALL_CNT_EN adds stall_cnt_o, a count of
// edges with out_valid_o & ~out_ready_i & ~flush_i.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   flush_i                   synchronous flush, empties both entries
//   in_valid_i / in_ready_o   upstream handshake (in_ready_o registered)
//   in_instr_i, in_pc_i       instruction word and PC
//   in_ops_i, in_ext_i        operand words and extended immediate
//   in_tnew_i, in_excode_i    cycles-until-result and exception code
//   out_valid_o / out_ready_i downstream handshake
//   out_*                     MAIN entry fields; nop when out_valid_o = 0
//   stall_cnt_o               stall counter (PIPE_STALL_CNT_EN only)
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_OPS = 2,
  parameter int unsigned TNEW_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               in_instr_i,
  input  logic [31:0]               in_pc_i,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops_i,
  input  logic [DATA_W-1:0]         in_ext_i,
  input  logic [TNEW_W-1:0]         in_tnew_i,
  input  logic [6:0]                in_excode_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [31:0]               out_instr_o,
  output logic [31:0]               out_pc_o,
  output logic [NUM_OPS*DATA_W-1:0] out_ops_o,
  output logic [DATA_W-1:0]         out_ext_o,
  output logic [TNEW_W-1:0]         out_tnew_o,
  output logic [6:0]                out_excode_o
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam int unsigned OPS_W = NUM_OPS * DATA_W;

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [OPS_W-1:0]  ops;
    logic [DATA_W-1:0] ext;
    logic [TNEW_W-1:0] tnew;
    logic [6:0]        excode;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // no entry held
    S_MAIN  = 2'd1,  // MAIN valid, SKID empty
    S_FULL  = 2'd2   // MAIN and SKID valid
  } state_t;

  state_t state, state_next;
  entry_t main_q, skid_q, in_entry;
  logic   accept, xfer;
  logic   load_main_in, load_main_skid, load_skid;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  assign accept = in_valid_i & in_ready_o & ~flush_i;
  assign xfer   = out_valid_o & out_ready_i;

  // Incoming entry with its Tnew already aged by the capturing edge.
  always_comb begin
    in_entry        = '0;
    in_entry.instr  = in_instr_i;
    in_entry.pc     = in_pc_i;
    in_entry.ops    = in_ops_i;
    in_entry.ext    = in_ext_i;
    in_entry.tnew   = sat_dec(in_tnew_i);
    in_entry.excode = in_excode_i;
  end

  // Occupancy next-state and entry-movement decode; flush overrides all.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_next   = S_MAIN;
        end
      end
      S_MAIN: begin
        if (accept && xfer) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = S_FULL;
        end else if (xfer) begin
          state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready_o is low here, so only the SKID->MAIN move can happen.
        if (xfer) begin
          load_main_skid = 1'b1;
          state_next     = S_MAIN;
        end
      end
      default: state_next = S_EMPTY;
    endcase
    if (flush_i) begin
      state_next     = S_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // State, handshake outputs and entry storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state       <= state_next;
      out_valid_o <= (state_next != S_EMPTY);
      in_ready_o  <= (state_next != S_FULL);

      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q      <= skid_q;
        main_q.tnew <= sat_dec(skid_q.tnew);
      end else if (state_next == S_EMPTY) begin
        // Bubble reads as a nop; ops/ext keep their stale contents.
        main_q.instr  <= '0;
        main_q.pc     <= '0;
        main_q.tnew   <= '0;
        main_q.excode <= '0;
      end else begin
        main_q.tnew <= sat_dec(main_q.tnew);
      end

      if (load_skid) begin
        skid_q <= in_entry;
      end else begin
        skid_q.tnew <= sat_dec(skid_q.tnew);
      end
    end
  end

  assign out_instr_o  = main_q.instr;
  assign out_pc_o     = main_q.pc;
  assign out_ops_o    = main_q.ops;
  assign out_ext_o    = main_q.ext;
  assign out_tnew_o   = main_q.tnew;
  assign out_excode_o = main_q.excode;

`ifdef PIPE_STALL_CNT_EN
  // Edges on which a valid output is held back by downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_o <= '0;
    end else if (out_valid_o && !out_ready_i && !flush_i) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: a queue model of the stage
// contents (max two entries, in order) plus per-entry capture edge numbers
// gives expected outputs, handshakes and Tnew ageing.
module tb_pipe_stage_skid_reg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OPS = 2;
  localparam int unsigned TNEW_W  = 3;
  localparam int unsigned OPS_W   = NUM_OPS * DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [31:0]       in_instr_i = '0;
  logic [31:0]       in_pc_i = '0;
  logic [OPS_W-1:0]  in_ops_i = '0;
  logic [DATA_W-1:0] in_ext_i = '0;
  logic [TNEW_W-1:0] in_tnew_i = '0;
  logic [6:0]        in_excode_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [31:0]       out_instr_o;
  logic [31:0]       out_pc_o;
  logic [OPS_W-1:0]  out_ops_o;
  logic [DATA_W-1:0] out_ext_o;
  logic [TNEW_W-1:0] out_tnew_o;
  logic [6:0]        out_excode_o;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
  logic [31:0]       stall_m = '0;
`endif

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .TNEW_W(TNEW_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i), .in_ops_i(in_ops_i),
    .in_ext_i(in_ext_i), .in_tnew_i(in_tnew_i), .in_excode_i(in_excode_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .out_ops_o(out_ops_o),
    .out_ext_o(out_ext_o), .out_tnew_o(out_tnew_o), .out_excode_o(out_excode_o)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [OPS_W-1:0]  ops;
    logic [DATA_W-1:0] ext;
    logic [6:0]        exc;
    int                tnew_in;
    int                cap;      // edge count when issued; captured on the next edge
  } item_t;

  item_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    edge_n   = 0;
  int    occ_now  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected Tnew: input value minus edges spent in the stage, floored at 0.
  function automatic int exp_tnew(input item_t it);
    int e;
    e = it.tnew_in - (edge_n - it.cap);
    return (e < 0) ? 0 : e;
  endfunction

  // Monitor: state checks 1 after the edge, pop/flush bookkeeping 4 after.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      occ_now = q.size();
      chk("out_valid", 64'(out_valid_o), 64'(occ_now > 0));
      chk("in_ready", 64'(in_ready_o), 64'(occ_now < 2));
      if (occ_now > 0) begin
        chk("out_instr", 64'(out_instr_o), 64'(q[0].instr));
        chk("out_pc", 64'(out_pc_o), 64'(q[0].pc));
        chk("out_ops", 64'(out_ops_o), 64'(q[0].ops));
        chk("out_ext", 64'(out_ext_o), 64'(q[0].ext));
        chk("out_excode", 64'(out_excode_o), 64'(q[0].exc));
        chk("out_tnew", 64'(out_tnew_o), 64'(exp_tnew(q[0])));
      end else begin
        chk("bubble_instr", 64'(out_instr_o), 64'd0);
        chk("bubble_pc", 64'(out_pc_o), 64'd0);
        chk("bubble_excode", 64'(out_excode_o), 64'd0);
        chk("bubble_tnew", 64'(out_tnew_o), 64'd0);
      end
`ifdef PIPE_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cnt_o), 64'(stall_m));
`endif
      #3;
      if (reset_n) begin
        if (flush_i) begin
          q.delete();
        end else begin
`ifdef PIPE_STALL_CNT_EN
          if (occ_now > 0 && !out_ready_i) stall_m = stall_m + 32'd1;
`endif
          if (occ_now > 0 && out_ready_i) void'(q.pop_front());
        end
      end
    end
  end

  // Driver: inputs change 3 after the edge; accepted items go to the scoreboard.
  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic [TNEW_W-1:0] tnew, input logic [6:0] exc);
    item_t it;
    @(posedge clk);
    #3;
    in_valid_i  = v;
    out_ready_i = r;
    flush_i     = f;
    in_instr_i  = instr;
    in_pc_i     = pc;
    in_ops_i    = {$urandom, $urandom};
    in_ext_i    = $urandom;
    in_tnew_i   = tnew;
    in_excode_i = exc;
    if (reset_n && v && !f && q.size() < 2) begin
      it.instr   = instr;
      it.pc      = pc;
      it.ops     = in_ops_i;
      it.ext     = in_ext_i;
      it.exc     = exc;
      it.tnew_in = int'(tnew);
      it.cap     = edge_n;
      q.push_back(it);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready_o), 64'd1);
    chk({tag, "_instr"}, 64'(out_instr_o), 64'd0);
    chk({tag, "_pc"}, 64'(out_pc_o), 64'd0);
    chk({tag, "_ops"}, 64'(out_ops_o), 64'd0);
    chk({tag, "_ext"}, 64'(out_ext_o), 64'd0);
    chk({tag, "_tnew"}, 64'(out_tnew_o), 64'd0);
    chk({tag, "_excode"}, 64'(out_excode_o), 64'd0);
`ifdef PIPE_STALL_CNT_EN
    chk({tag, "_stall"}, 64'(stall_cnt_o), 64'd0);
`endif
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 check_all_zero("rst");
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Streaming at full rate.
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b1, 1'b0, 32'h2408_0005 + 32'(i), 32'h0000_3000 + 32'(4 * i), 3'd2, 7'd0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Backpressure: A in MAIN, B into SKID, then drain in order.
    drive(1'b1, 1'b0, 1'b0, 32'hAAAA_0001, 32'h100, 3'd3, 7'd0);
    drive(1'b1, 1'b0, 1'b0, 32'hBBBB_0002, 32'h104, 3'd5, 7'd0);
    drive(1'b1, 1'b0, 1'b0, 32'hCCCC_0003, 32'h108, 3'd1, 7'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Flush with both entries full and a valid input present.
    drive(1'b1, 1'b0, 1'b0, 32'h1111_0001, 32'h200, 3'd4, 7'd3);
    drive(1'b1, 1'b0, 1'b0, 32'h1111_0002, 32'h204, 3'd4, 7'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h1111_0003, 32'h208, 3'd4, 7'd0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Stall counting with MAIN held for five edges.
    drive(1'b1, 1'b0, 1'b0, 32'h5555_0001, 32'h300, 3'd7, 7'd0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Asynchronous reset between edges while stalled and full.
    drive(1'b1, 1'b0, 1'b0, 32'h7777_0001, 32'h400, 3'd2, 7'd5);
    drive(1'b1, 1'b0, 1'b0, 32'h7777_0002, 32'h404, 3'd2, 7'd6);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    #4 reset_n = 1'b0;
    q.delete();
`ifdef PIPE_STALL_CNT_EN
    stall_m = '0;
`endif
    #1 check_all_zero("arst");
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Exception code and PC pass through, then clear on the bubble.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_3004, 3'd1, 7'h0A);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
            $urandom, $urandom, 3'($urandom % 8), 7'($urandom % 128));

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
